parking_cu_sched: RTL and testbench

- Parametrised successor to the parking control unit: a fully synchronous occupancy controller for a two-class car park (university and regular).
- Regular capacity follows an hourly schedule (base / peak / ramp) driven by an internal time-of-day counter.
- Entry and exit are single-cycle request pulses with registered grant/deny and ack/err responses.
- Sits between the gate sensors and the display/barrier logic.

---
 rtl/parking_cu_sched_if.sv | 55 +++++
 rtl/parking_cu_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_parking_cu_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_cu_sched_if.sv
// ---------------------------------------------------------------------------
// parking_cu_sched_if
// Bundles the gate-side request/response signals and the occupancy status
// outputs of parking_cu_sched.
//   master : gate-sensor side. Drives the entry/exit requests and observes
//            the responses and status.
//   slave  : the controller itself.
// Parameter CNT_W : occupancy counter width (free counts are CNT_W+1 signed).
// Optional macro PARKING_STATS_EN adds three 16-bit statistics counters.
// ---------------------------------------------------------------------------
interface parking_cu_sched_if #(
  parameter int CNT_W = 10
);
  logic                    entry_req;
  logic                    entry_uni;
  logic                    exit_req;
  logic                    exit_uni;
  logic                    entry_grant;
  logic                    entry_deny;
  logic                    exit_ack;
  logic                    exit_err;
  logic [CNT_W-1:0]        uni_parked;
  logic [CNT_W-1:0]        reg_parked;
  logic signed [CNT_W:0]   uni_free;
  logic signed [CNT_W:0]   reg_free;
  logic                    uni_has_space;
  logic                    reg_has_space;
  logic [4:0]              hour;
  logic [CNT_W-1:0]        reg_cap;
`ifdef PARKING_STATS_EN
  logic [15:0]             deny_uni_cnt;
  logic [15:0]             deny_reg_cnt;
  logic [15:0]             exit_err_cnt;
`endif

  modport master (
    output entry_req, entry_uni, exit_req, exit_uni,
    input  entry_grant, entry_deny, exit_ack, exit_err,
    input  uni_parked, reg_parked, uni_free, reg_free,
    input  uni_has_space, reg_has_space, hour, reg_cap
`ifdef PARKING_STATS_EN
    , input deny_uni_cnt, deny_reg_cnt, exit_err_cnt
`endif
  );

  modport slave (
    input  entry_req, entry_uni, exit_req, exit_uni,
    output entry_grant, entry_deny, exit_ack, exit_err,
    output uni_parked, reg_parked, uni_free, reg_free,
    output uni_has_space, reg_has_space, hour, reg_cap
`ifdef PARKING_STATS_EN
    , output deny_uni_cnt, deny_reg_cnt, exit_err_cnt
`endif
  );
endinterface

// File: rtl/parking_cu_sched.sv
// ---------------------------------------------------------------------------
// parking_cu_sched
// Occupancy controller for a two-class (university / regular) car park.
// Regular capacity follows an hourly schedule (base / peak / ramp) driven by
// an internal time-of-day counter. Entry and exit are one-cycle requests
// answered one cycle later with one-cycle grant/deny and ack/err pulses.
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : parking_cu_sched_if.slave
//            in : entry_req, entry_uni, exit_req, exit_uni
//            out: entry_grant, entry_deny, exit_ack, exit_err,
//                 uni_parked, reg_parked, uni_free, reg_free (signed),
//                 uni_has_space, reg_has_space, hour, reg_cap
//
// Optional macro PARKING_STATS_EN: adds 16-bit saturating counters
// deny_uni_cnt, deny_reg_cnt and exit_err_cnt, cleared by reset and on the
// hour 23->0 wrap.
// ---------------------------------------------------------------------------
module parking_cu_sched #(
  parameter int TOTAL_CAP      = 700,
  parameter int REG_CAP_BASE   = 500,
  parameter int REG_CAP_PEAK   = 200,
  parameter int PEAK_START     = 8,
  parameter int PEAK_END       = 13,
  parameter int RAMP_HOURS     = 3,
  parameter int RAMP_STEP      = 50,
  parameter int TICKS_PER_HOUR = 3600,
  parameter int CNT_W          = 10
) (
  input logic              clk,
  input logic              rst_n,
  parking_cu_sched_if.slave bus
);

  localparam int TICK_W = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;

  typedef logic signed [CNT_W:0] sval_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  localparam sval_t TOTAL_S = sval_t'(TOTAL_CAP);
  localparam cnt_t  ONE     = cnt_t'(1);

  // Zero-extend an occupancy count into the signed free-space domain.
  function automatic sval_t sx(input cnt_t v);
    return sval_t'({1'b0, v});
  endfunction

  function automatic cnt_t cap_for_hour(input logic [4:0] h);
    int hi;
    hi = int'(h);
    if (hi >= PEAK_START && hi < PEAK_END)
      return cnt_t'(REG_CAP_PEAK);
    else if (hi >= PEAK_END && hi < PEAK_END + RAMP_HOURS)
      return cnt_t'(REG_CAP_PEAK + (hi - PEAK_END + 1) * RAMP_STEP);
    return cnt_t'(REG_CAP_BASE);
  endfunction

  function automatic sval_t uni_free_of(input cnt_t u, input cnt_t r);
    return TOTAL_S - (sx(u) + sx(r));
  endfunction

  // Once university cars spill past their share, the regular area is bounded
  // by the whole car park rather than by the regular capacity.
  function automatic sval_t reg_free_of(input cnt_t u, input cnt_t r, input cnt_t cap);
    if (sx(u) > TOTAL_S - sx(cap))
      return TOTAL_S - (sx(u) + sx(r));
    return sx(cap) - sx(r);
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_q;
  logic [4:0]        hour_q;
  cnt_t              cap_q;
  cnt_t              uni_q;
  cnt_t              reg_q;
  logic              grant_q;
  logic              deny_q;
  logic              ack_q;
  logic              err_q;

  // -------------------------------------------------------------------------
  // Timekeeping
  // -------------------------------------------------------------------------
  logic       tick_wrap;
  logic       day_wrap;
  logic [4:0] hour_next;

  assign tick_wrap = (tick_q == TICK_W'(TICKS_PER_HOUR - 1));
  assign day_wrap  = tick_wrap && (hour_q == 5'd23);
  assign hour_next = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      hour_q <= '0;
      cap_q  <= cnt_t'(REG_CAP_BASE);
    end else if (tick_wrap) begin
      tick_q <= '0;
      hour_q <= hour_next;
      // Capacity moves on the same edge as the hour, so it never lags.
      cap_q  <= cap_for_hour(hour_next);
    end else begin
      tick_q <= tick_q + TICK_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Request handling: apply the exit first, then admit against the counts
  // that result, so a space freed this cycle can be reused immediately.
  // -------------------------------------------------------------------------
  logic exit_ok;
  logic admit;
  cnt_t uni_ae;
  cnt_t reg_ae;
  cnt_t uni_d;
  cnt_t reg_d;

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    exit_ok = 1'b0;
    admit   = 1'b0;
    uni_ae  = uni_q;
    reg_ae  = reg_q;

    if (bus.exit_req)
      exit_ok = bus.exit_uni ? (uni_q != '0) : (reg_q != '0);
    if (exit_ok) begin
      if (bus.exit_uni) uni_ae = uni_q - ONE;
      else              reg_ae = reg_q - ONE;
    end

    // cap_q is still the pre-edge value here, even on an hour boundary.
    if (bus.entry_req)
      admit = bus.entry_uni ? (uni_free_of(uni_ae, reg_ae) > sval_t'(0))
                            : (reg_free_of(uni_ae, reg_ae, cap_q) > sval_t'(0));

    uni_d = uni_ae;
    reg_d = reg_ae;
    if (admit) begin
      if (bus.entry_uni) uni_d = uni_ae + ONE;
      else               reg_d = reg_ae + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uni_q   <= '0;
      reg_q   <= '0;
      grant_q <= 1'b0;
      deny_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      uni_q   <= uni_d;
      reg_q   <= reg_d;
      grant_q <= admit;
      deny_q  <= bus.entry_req & ~admit;
      ack_q   <= exit_ok;
      err_q   <= bus.exit_req & ~exit_ok;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  sval_t uni_free_w;
  sval_t reg_free_w;

  assign uni_free_w = uni_free_of(uni_q, reg_q);
  assign reg_free_w = reg_free_of(uni_q, reg_q, cap_q);

  assign bus.entry_grant   = grant_q;
  assign bus.entry_deny    = deny_q;
  assign bus.exit_ack      = ack_q;
  assign bus.exit_err      = err_q;
  assign bus.uni_parked    = uni_q;
  assign bus.reg_parked    = reg_q;
  assign bus.uni_free      = uni_free_w;
  assign bus.reg_free      = reg_free_w;
  assign bus.uni_has_space = (uni_free_w > sval_t'(0));
  assign bus.reg_has_space = (reg_free_w > sval_t'(0));
  assign bus.hour          = hour_q;
  assign bus.reg_cap       = cap_q;

`ifdef PARKING_STATS_EN
  // -------------------------------------------------------------------------
  // Statistics: count on the same edge that raises the matching pulse.
  // The daily clear takes priority over an event on the wrap edge.
  // -------------------------------------------------------------------------
  logic [15:0] deny_uni_q;
  logic [15:0] deny_reg_q;
  logic [15:0] err_cnt_q;
  logic        deny_uni_ev;
  logic        deny_reg_ev;
  logic        err_ev;

  assign deny_uni_ev = bus.entry_req &  bus.entry_uni & ~admit;
  assign deny_reg_ev = bus.entry_req & ~bus.entry_uni & ~admit;
  assign err_ev      = bus.exit_req & ~exit_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deny_uni_q <= '0;
      deny_reg_q <= '0;
      err_cnt_q  <= '0;
    end else if (day_wrap) begin
      deny_uni_q <= '0;
      deny_reg_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (deny_uni_ev && deny_uni_q != 16'hFFFF) deny_uni_q <= deny_uni_q + 16'd1;
      if (deny_reg_ev && deny_reg_q != 16'hFFFF) deny_reg_q <= deny_reg_q + 16'd1;
      if (err_ev      && err_cnt_q  != 16'hFFFF) err_cnt_q  <= err_cnt_q  + 16'd1;
    end
  end

  assign bus.deny_uni_cnt = deny_uni_q;
  assign bus.deny_reg_cnt = deny_reg_q;
  assign bus.exit_err_cnt = err_cnt_q;
`else
  logic unused_day_wrap;
  assign unused_day_wrap = day_wrap;
`endif

endmodule

// File: tb/tb_parking_cu_sched.sv
// ---------------------------------------------------------------------------
// tb_parking_cu_sched
// Self-checking bench for parking_cu_sched. A behavioural model tracks the
// two class counts and derives the hour from the number of clock edges since
// reset; expected responses come from the admission rules applied to that
// model. Honours PARKING_STATS_EN when defined.
// ---------------------------------------------------------------------------
module tb_parking_cu_sched;

  localparam int TPH   = 16;
  localparam int TOTAL = 10;
  localparam int BASE  = 6;
  localparam int PEAK  = 3;
  localparam int PS    = 1;
  localparam int PE    = 2;
  localparam int RH    = 2;
  localparam int STEP  = 1;
  localparam int CW    = 10;
  localparam int SW    = 2 * CW + 2 * (CW + 1) + 2 + 5 + CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  parking_cu_sched_if #(.CNT_W(CW)) bus ();

  parking_cu_sched #(
    .TOTAL_CAP(TOTAL), .REG_CAP_BASE(BASE), .REG_CAP_PEAK(PEAK),
    .PEAK_START(PS), .PEAK_END(PE), .RAMP_HOURS(RH), .RAMP_STEP(STEP),
    .TICKS_PER_HOUR(TPH), .CNT_W(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model
  int m_uni;
  int m_reg;
  int n_edges;
  logic [3:0] x_pulses;  // {grant, deny, ack, err} expected after the last step
`ifdef PARKING_STATS_EN
  int m_deny_uni;
  int m_deny_reg;
  int m_exit_err;
`endif

  function automatic int cap_of(int h);
    if (h >= PS && h < PE) return PEAK;
    if (h >= PE && h < PE + RH) return PEAK + (h - PE + 1) * STEP;
    return BASE;
  endfunction

  function automatic int uni_free_of(int u, int r);
    return TOTAL - u - r;
  endfunction

  function automatic int reg_free_of(int u, int r, int cap);
    return (u > TOTAL - cap) ? TOTAL - u - r : cap - r;
  endfunction

  function automatic int hour_now();
    return (n_edges / TPH) % 24;
  endfunction

  function automatic logic [SW-1:0] pack_exp(int u, int r, int h);
    int uf, rf;
    uf = uni_free_of(u, r);
    rf = reg_free_of(u, r, cap_of(h));
    return {CW'(u), CW'(r), (CW+1)'(uf), (CW+1)'(rf), uf > 0, rf > 0, 5'(h), CW'(cap_of(h))};
  endfunction

  function automatic logic [SW-1:0] pack_dut();
    return {bus.uni_parked, bus.reg_parked, bus.uni_free, bus.reg_free,
            bus.uni_has_space, bus.reg_has_space, bus.hour, bus.reg_cap};
  endfunction

  function automatic logic [3:0] pulses();
    return {bus.entry_grant, bus.entry_deny, bus.exit_ack, bus.exit_err};
  endfunction

  // Drive one cycle of requests, advance the model, return #1 after the edge.
  task automatic step(input bit e, input bit eu, input bit x, input bit xu);
    int cap, u, r;
    cap = cap_of(hour_now());
    u = m_uni;
    r = m_reg;
    x_pulses = 4'b0000;
    if (x) begin
      if (xu ? (u > 0) : (r > 0)) begin
        x_pulses[1] = 1'b1;
        if (xu) u--; else r--;
      end else begin
        x_pulses[0] = 1'b1;
      end
    end
    if (e) begin
      if ((eu ? uni_free_of(u, r) : reg_free_of(u, r, cap)) > 0) begin
        x_pulses[3] = 1'b1;
        if (eu) u++; else r++;
      end else begin
        x_pulses[2] = 1'b1;
      end
    end
    bus.entry_req = e;
    bus.entry_uni = eu;
    bus.exit_req  = x;
    bus.exit_uni  = xu;
    @(posedge clk);
    #1;
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    n_edges++;
    m_uni = u;
    m_reg = r;
`ifdef PARKING_STATS_EN
    if (n_edges % (24 * TPH) == 0) begin
      m_deny_uni = 0;
      m_deny_reg = 0;
      m_exit_err = 0;
    end else begin
      if (x_pulses[2] && eu && m_deny_uni < 65535) m_deny_uni++;
      if (x_pulses[2] && !eu && m_deny_reg < 65535) m_deny_reg++;
      if (x_pulses[0] && m_exit_err < 65535) m_exit_err++;
    end
`endif
  endtask

  task automatic idle_until_hour(input int h);
    while (hour_now() != h) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    bus.entry_req = 1'b0;
    bus.entry_uni = 1'b0;
    bus.exit_req  = 1'b0;
    bus.exit_uni  = 1'b0;
    rst_n = 1'b0;
    #7;
    @(negedge clk);
    rst_n = 1'b1;
    m_uni = 0;
    m_reg = 0;
    n_edges = 0;
    x_pulses = 4'b0000;
`ifdef PARKING_STATS_EN
    m_deny_uni = 0;
    m_deny_reg = 0;
    m_exit_err = 0;
`endif
  endtask

  task automatic test_reset();
    logic [SW-1:0] want;
    do_reset();
    want = pack_exp(0, 0, 0);
    n_checks++;
    if (pack_dut() !== want) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", pack_dut(), want);
    end
    n_checks++;
    if (pulses() !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b want 0000", pulses());
    end
    n_checks++;
    if (bus.reg_cap !== CW'(BASE) || bus.uni_free !== 11'sd10 || bus.reg_free !== 11'sd6) begin
      n_fail++;
      $display("FAIL reset_caps: cap %0d uni_free %0d reg_free %0d want 6 10 6",
               bus.reg_cap, bus.uni_free, bus.reg_free);
    end
  endtask

  task automatic test_reg_fill();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({bus.entry_grant, bus.entry_deny} !== ((i < 6) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL reg_fill_%0d: grant/deny %b%b", i, bus.entry_grant, bus.entry_deny);
      end
    end
    n_checks++;
    if (bus.reg_free !== 11'sd0 || bus.reg_has_space !== 1'b0 || bus.reg_parked !== 10'd6) begin
      n_fail++;
      $display("FAIL reg_full: reg_free %0d has_space %b parked %0d want 0 0 6",
               bus.reg_free, bus.reg_has_space, bus.reg_parked);
    end
  endtask

  task automatic test_schedule();
    logic [CW-1:0] want_cap [3];
    want_cap = '{10'd4, 10'd5, 10'd6};
    idle_until_hour(1);
    n_checks++;
    if (bus.hour !== 5'd1 || bus.reg_cap !== 10'd3 || bus.reg_free !== -11'sd3) begin
      n_fail++;
      $display("FAIL peak_cut: hour %0d cap %0d reg_free %0d want 1 3 -3",
               bus.hour, bus.reg_cap, bus.reg_free);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (pulses() !== 4'b0100) begin
      n_fail++;
      $display("FAIL peak_deny: pulses %b want 0100", pulses());
    end
    for (int h = 2; h <= 4; h++) begin
      idle_until_hour(h);
      n_checks++;
      if (bus.hour !== 5'(h) || bus.reg_cap !== want_cap[h-2]) begin
        n_fail++;
        $display("FAIL ramp_h%0d: hour %0d cap %0d want %0d", h, bus.hour, bus.reg_cap, want_cap[h-2]);
      end
    end
  endtask

  task automatic test_uni_overflow();
    do_reset();
    idle_until_hour(1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (bus.entry_grant !== 1'b1) begin
        n_fail++;
        $display("FAIL uni_grant_%0d: grant %b want 1", i, bus.entry_grant);
      end
    end
    n_checks++;
    if (bus.reg_free !== 11'sd2 || bus.uni_parked !== 10'd8) begin
      n_fail++;
      $display("FAIL uni_overflow: reg_free %0d uni %0d want 2 8", bus.reg_free, bus.uni_parked);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({bus.entry_grant, bus.entry_deny} !== ((i < 2) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL overflow_reg_%0d: grant/deny %b%b", i, bus.entry_grant, bus.entry_deny);
      end
    end
    n_checks++;
    if (bus.uni_free !== 11'sd0 || bus.uni_has_space !== 1'b0) begin
      n_fail++;
      $display("FAIL park_full: uni_free %0d has_space %b want 0 0", bus.uni_free, bus.uni_has_space);
    end
  endtask

  // Continues from a full car park (8 uni + 2 regular) at hour 1.
  task automatic test_back_to_back();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (pulses() !== 4'b1010) begin
      n_fail++;
      $display("FAIL swap_pulses: pulses %b want 1010", pulses());
    end
    n_checks++;
    if (bus.uni_parked !== 10'd9 || bus.reg_parked !== 10'd1) begin
      n_fail++;
      $display("FAIL swap_counts: uni %0d reg %0d want 9 1", bus.uni_parked, bus.reg_parked);
    end
  endtask

  task automatic test_exit_err();
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (pulses() !== 4'b0001 || bus.uni_parked !== 10'd0 || bus.reg_parked !== 10'd0) begin
      n_fail++;
      $display("FAIL exit_err: pulses %b uni %0d reg %0d want 0001 0 0",
               pulses(), bus.uni_parked, bus.reg_parked);
    end
`ifdef PARKING_STATS_EN
    n_checks++;
    if (bus.exit_err_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL exit_err_cnt: got %0d want 1", bus.exit_err_cnt);
    end
`endif
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    bus.entry_req = 1'b1;
    bus.entry_uni = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pack_dut() !== pack_exp(0, 0, 0) || pulses() !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async: state %h pulses %b want %h 0000", pack_dut(), pulses(), pack_exp(0, 0, 0));
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (pulses() !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_drop: pulses %b want 0000", pulses());
    end
    bus.entry_req = 1'b0;
  endtask

  task automatic test_random();
    bit e, eu, x, xu;
    do_reset();
    for (int c = 0; c < 420; c++) begin
      e  = ($urandom_range(0, 99) < 60);
      eu = 1'($urandom_range(0, 1));
      x  = ($urandom_range(0, 99) < 35);
      xu = 1'($urandom_range(0, 1));
      step(e, eu, x, xu);
      n_checks++;
      if (pulses() !== x_pulses) begin
        n_fail++;
        $display("FAIL rand_pulses cyc %0d: got %b want %b", c, pulses(), x_pulses);
      end
      n_checks++;
      if (pack_dut() !== pack_exp(m_uni, m_reg, hour_now())) begin
        n_fail++;
        $display("FAIL rand_state cyc %0d: got %h want %h", c, pack_dut(), pack_exp(m_uni, m_reg, hour_now()));
      end
`ifdef PARKING_STATS_EN
      n_checks++;
      if (bus.deny_uni_cnt !== 16'(m_deny_uni) || bus.deny_reg_cnt !== 16'(m_deny_reg) ||
          bus.exit_err_cnt !== 16'(m_exit_err)) begin
        n_fail++;
        $display("FAIL rand_stats cyc %0d: got %0d %0d %0d want %0d %0d %0d", c,
                 bus.deny_uni_cnt, bus.deny_reg_cnt, bus.exit_err_cnt, m_deny_uni, m_deny_reg, m_exit_err);
      end
`endif
    end
  endtask

  initial begin
    bus.entry_req = 1'b0;
    bus.entry_uni = 1'b0;
    bus.exit_req  = 1'b0;
    bus.exit_uni  = 1'b0;
    test_reset();
    test_reg_fill();
    test_schedule();
    test_uni_overflow();
    test_back_to_back();
    test_exit_err();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1, "time limit");
  end

endmodule
